// File: rtl/cr_cceip_64_sa_counter.sv
// Statistics-aggregator counter core: 64 saturating live counters, each counting one
// selectable event strobe, with edge-triggered atomic snapshot and clear of all counters.
module cr_cceip_64_sa_counter #(
  parameter int N_COUNTERS = 64,
  parameter int N_EVENTS   = 128,
  parameter int N_SEL_BITS = 7,
  parameter int N_CNT_BITS = 50,
  parameter int CTRL_W     = N_SEL_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_EVENTS-1:0]   sa_events,
  input  logic [CTRL_W-1:0]     regs_sa_ctrl [0:N_COUNTERS-1],
  input  logic                  regs_sa_snap,
  input  logic                  regs_sa_clear_live,
  output logic [N_CNT_BITS-1:0] sa_count     [0:N_COUNTERS-1],
  output logic [N_CNT_BITS-1:0] sa_snapshot  [0:N_COUNTERS-1]
);

  localparam logic [N_CNT_BITS-1:0] CNT_MAX = '1;

  logic [N_EVENTS-1:0]   ev_q;
  logic [CTRL_W-1:0]     ctrl_q     [0:N_COUNTERS-1];
  logic                  snap_q;
  logic                  clr_q;
  logic [N_CNT_BITS-1:0] count_q    [0:N_COUNTERS-1];
  logic [N_CNT_BITS-1:0] count_d    [0:N_COUNTERS-1];
  logic [N_CNT_BITS-1:0] snapshot_q [0:N_COUNTERS-1];
  logic [N_COUNTERS-1:0] hit;
  logic                  snap_p;
  logic                  clr_p;

  // Software levels become one-shot requests on their rising edge only.
  assign snap_p = regs_sa_snap & ~snap_q;
  assign clr_p  = regs_sa_clear_live & ~clr_q;

  always_comb begin
    for (int i = 0; i < N_COUNTERS; i++) begin
      hit[i]     = ctrl_q[i][N_SEL_BITS] & ev_q[ctrl_q[i][N_SEL_BITS-1:0]];
      count_d[i] = count_q[i];
      // Clear beats a same-cycle hit; saturation holds at all-ones.
      if (clr_p) begin
        count_d[i] = '0;
      end else if (hit[i] && (count_q[i] != CNT_MAX)) begin
        count_d[i] = count_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q   <= '0;
      snap_q <= 1'b0;
      clr_q  <= 1'b0;
      for (int i = 0; i < N_COUNTERS; i++) begin
        ctrl_q[i]     <= '0;
        count_q[i]    <= '0;
        snapshot_q[i] <= '0;
      end
    end else begin
      ev_q   <= sa_events;
      snap_q <= regs_sa_snap;
      clr_q  <= regs_sa_clear_live;
      for (int i = 0; i < N_COUNTERS; i++) begin
        ctrl_q[i]  <= regs_sa_ctrl[i];
        count_q[i] <= count_d[i];
        // Snapshot takes the registered count, so it is pre-hit and pre-clear.
        if (snap_p) begin
          snapshot_q[i] <= count_q[i];
        end
      end
    end
  end

  assign sa_count    = count_q;
  assign sa_snapshot = snapshot_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_counter.sv
// Bench for cr_cceip_64_sa_counter: a 50-bit instance and a 6-bit instance share stimulus so
// saturation is reachable; a behavioural model is compared every cycle plus literal checks.
module tb_cr_cceip_64_sa_counter;

  localparam int NC  = 64;
  localparam int NE  = 128;
  localparam int SB  = 7;
  localparam int CW  = 50;
  localparam int CWS = 6;
  localparam int CTW = SB + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NE-1:0]  sa_events = '0;
  logic [CTW-1:0] ctrl [0:NC-1];
  logic           snap = 1'b0;
  logic           clr = 1'b0;

  logic [CW-1:0]  cnt_b [0:NC-1];
  logic [CW-1:0]  snp_b [0:NC-1];
  logic [CWS-1:0] cnt_s [0:NC-1];
  logic [CWS-1:0] snp_s [0:NC-1];

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  cr_cceip_64_sa_counter dut_b (
    .clk                (clk),
    .rst_n              (rst_n),
    .sa_events          (sa_events),
    .regs_sa_ctrl       (ctrl),
    .regs_sa_snap       (snap),
    .regs_sa_clear_live (clr),
    .sa_count           (cnt_b),
    .sa_snapshot        (snp_b)
  );

  cr_cceip_64_sa_counter #(.N_CNT_BITS(CWS)) dut_s (
    .clk                (clk),
    .rst_n              (rst_n),
    .sa_events          (sa_events),
    .regs_sa_ctrl       (ctrl),
    .regs_sa_snap       (snap),
    .regs_sa_clear_live (clr),
    .sa_count           (cnt_s),
    .sa_snapshot        (snp_s)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Counts are plain integers; an event presented on one edge is counted on the next edge
  // using the control word presented alongside it.
  longint         m_cnt  [2][NC];
  longint         m_snap [2][NC];
  longint         m_max  [2];
  logic [NE-1:0]  m_ev_prev;
  logic [CTW-1:0] m_ctrl_prev [NC];
  logic           m_snap_prev;
  logic           m_clr_prev;

  initial begin
    m_max[0] = (longint'(1) << CW) - 1;
    m_max[1] = (longint'(1) << CWS) - 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ev_prev   = '0;
      m_snap_prev = 1'b0;
      m_clr_prev  = 1'b0;
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < NC; i++) begin
          m_cnt[u][i]  = 0;
          m_snap[u][i] = 0;
        end
      for (int i = 0; i < NC; i++) m_ctrl_prev[i] = '0;
    end else begin
      bit se;
      bit ce;
      se = snap && !m_snap_prev;
      ce = clr && !m_clr_prev;
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < NC; i++) begin
          bit h;
          h = m_ctrl_prev[i][SB] && m_ev_prev[m_ctrl_prev[i][SB-1:0]];
          if (se) m_snap[u][i] = m_cnt[u][i];
          if (ce) m_cnt[u][i] = 0;
          else if (h && m_cnt[u][i] < m_max[u]) m_cnt[u][i] = m_cnt[u][i] + 1;
        end
      m_ev_prev   = sa_events;
      m_snap_prev = snap;
      m_clr_prev  = clr;
      for (int i = 0; i < NC; i++) m_ctrl_prev[i] = ctrl[i];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int idx, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, idx, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NC; i++) begin
        check("model_cnt_b",  i, longint'(cnt_b[i]), m_cnt[0][i]);
        check("model_snap_b", i, longint'(snp_b[i]), m_snap[0][i]);
        check("model_cnt_s",  i, longint'(cnt_s[i]), m_cnt[1][i]);
        check("model_snap_s", i, longint'(snp_s[i]), m_snap[1][i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ctrl(input int i, input bit en, input int sel);
    logic [SB-1:0] s;
    s = SB'(sel);
    ctrl[i] = {en, s};
  endtask

  task automatic strobe(input int e);
    sa_events = '0;
    sa_events[e] = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    sa_events = '0;
    repeat (n) tick();
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NC; i++) ctrl[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_cnt0", 0, longint'(cnt_b[0]), 0);
    check("reset_snap63", 63, longint'(snp_b[63]), 0);

    // Basic count and two-cycle latency
    set_ctrl(0, 1'b1, 5);
    tick();
    strobe(5);
    check("latency_t1", 0, longint'(cnt_b[0]), 0);
    for (int k = 1; k < 10; k++) begin
      strobe(5);
      if (k == 1) check("latency_t2", 0, longint'(cnt_b[0]), 1);
    end
    idle(2);
    check("count10", 0, longint'(cnt_b[0]), 10);
    check("other_zero", 1, longint'(cnt_b[1]), 0);

    // Shared event, one counter disabled
    set_ctrl(3, 1'b1, 20);
    set_ctrl(7, 1'b1, 20);
    tick();
    set_ctrl(7, 1'b0, 20);
    tick();
    repeat (4) strobe(20);
    idle(2);
    check("shared_en", 3, longint'(cnt_b[3]), 4);
    check("shared_dis", 7, longint'(cnt_b[7]), 0);

    // Saturation on the narrow instance
    set_ctrl(2, 1'b1, 30);
    tick();
    repeat (62) strobe(30);
    idle(2);
    check("sat_pre", 2, longint'(cnt_s[2]), 62);
    repeat (3) strobe(30);
    idle(2);
    check("sat_stick", 2, longint'(cnt_s[2]), 63);
    check("sat_wide", 2, longint'(cnt_b[2]), 65);

    // Snapshot captured once while the level stays high
    pulse_clear();
    check("clear0", 0, longint'(cnt_b[0]), 0);
    repeat (100) strobe(5);
    idle(2);
    check("count100", 0, longint'(cnt_b[0]), 100);
    snap = 1'b1;
    for (int k = 0; k < 5; k++) begin
      strobe(5);
      check("snap_hold", 0, longint'(snp_b[0]), 100);
    end
    snap = 1'b0;
    idle(2);
    check("count105", 0, longint'(cnt_b[0]), 105);
    check("snap_keep", 0, longint'(snp_b[0]), 100);
    check("snap_sat_s", 0, longint'(snp_s[0]), 63);

    // Atomic read-and-clear with a hit landing in the same cycle
    pulse_clear();
    repeat (51) strobe(5);
    snap = 1'b1;
    clr = 1'b1;
    sa_events = '0;
    tick();
    check("atomic_snap", 0, longint'(snp_b[0]), 50);
    check("atomic_clr", 0, longint'(cnt_b[0]), 0);
    snap = 1'b0;
    clr = 1'b0;
    strobe(5);
    idle(2);
    check("after_clr", 0, longint'(cnt_b[0]), 1);

    // Randomized traffic
    for (int i = 0; i < NC; i++) set_ctrl(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, NE - 1));
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0)
        set_ctrl($urandom_range(0, NC - 1), 1'($urandom_range(0, 1)), $urandom_range(0, NE - 1));
      sa_events = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) snap = ~snap;
      if ($urandom_range(0, 15) == 0) clr = ~clr;
      tick();
    end

    // Asynchronous reset in the middle of a burst
    snap = 1'b0;
    clr = 1'b0;
    set_ctrl(0, 1'b1, 5);
    repeat (5) strobe(5);
    sa_events[5] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_cnt", 0, longint'(cnt_b[0]), 0);
    check("async_snap", 0, longint'(snp_b[0]), 0);
    check("async_cnt_s", 0, longint'(cnt_s[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sa_events = '0;
    tick();
    repeat (3) strobe(5);
    idle(2);
    check("resume", 0, longint'(cnt_b[0]), 3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
